// File: rtl/mgmt_wb_pkg.sv
// Shared definitions for the management-to-user-project wishbone bridge:
// FSM encoding, default timeout read data and timeout counter width.
package mgmt_wb_pkg;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_BUSY = 2'd1,
        ST_RESP = 2'd2
    } wb_state_e;

    localparam logic [31:0] DEF_TIMEOUT_DATA = 32'hFFFF_FFFF;

    // Wide enough for the largest legal TIMEOUT_CYCLES (65535).
    localparam int CNT_W = $clog2(65536);

endpackage

// File: rtl/wb_timeout_cnt.sv
// Free-running timeout counter for one bridged transfer; expire flags the
// last permitted cycle while counting is enabled.
module wb_timeout_cnt
    import mgmt_wb_pkg::*;
#(
    parameter int unsigned LIMIT = 255
) (
    input  logic clk,
    input  logic rst,
    input  logic clear,
    input  logic enable,
    output logic expire
);

    localparam logic [CNT_W-1:0] LAST = CNT_W'(LIMIT - 32'd1);

    logic [CNT_W-1:0] cnt_r;

    // Counter register: clear has priority over counting.
    always_ff @(posedge clk) begin
        if (rst) begin
            cnt_r <= {CNT_W{1'b0}};
        end else if (clear) begin
            cnt_r <= {CNT_W{1'b0}};
        end else if (enable) begin
            cnt_r <= cnt_r + {{(CNT_W-1){1'b0}}, 1'b1};
        end else begin
            cnt_r <= cnt_r;
        end
    end

    assign expire = enable && (cnt_r == LAST);

endmodule

// File: rtl/mprj_wb_bridge.sv
// Registered wishbone bridge from the management core to the user project,
// with per-transfer ack timeout and a sticky timeout status.
module mprj_wb_bridge
    import mgmt_wb_pkg::*;
#(
    parameter int unsigned TIMEOUT_CYCLES = 255,
    parameter logic [31:0] TIMEOUT_DATA   = DEF_TIMEOUT_DATA
) (
    input  logic        core_clk,
    input  logic        core_rst,
    input  logic        mprj_cyc_i,
    input  logic        mprj_stb_i,
    input  logic        mprj_we_i,
    input  logic [3:0]  mprj_sel_i,
    input  logic [31:0] mprj_adr_i,
    input  logic [31:0] mprj_dat_i,
    output logic        mprj_ack_o,
    output logic [31:0] mprj_dat_o,
    output logic        wbs_cyc_o,
    output logic        wbs_stb_o,
    output logic        wbs_we_o,
    output logic [3:0]  wbs_sel_o,
    output logic [31:0] wbs_adr_o,
    output logic [31:0] wbs_dat_o,
    input  logic        wbs_ack_i,
    input  logic [31:0] wbs_dat_i,
    input  logic        mprj_wb_iena,
    input  logic        to_clear,
    output logic        to_flag,
    output logic [31:0] to_addr
);

    wb_state_e   state_r;
    logic        ack_gated_s;
    logic [31:0] dat_gated_s;
    logic        accept_s;
    logic        cnt_enable_s;
    logic        cnt_expire_s;
    logic        timeout_evt_s;

    // Response gating, request acceptance and timeout event decode.
    always_comb begin
        ack_gated_s  = wbs_ack_i & mprj_wb_iena;
        dat_gated_s  = mprj_wb_iena ? wbs_dat_i : 32'h0000_0000;
        // Holding off while mprj_ack_o is high keeps the finishing
        // transfer's still-asserted strobe from being taken as a new one.
        accept_s     = (state_r == ST_IDLE) && mprj_cyc_i && mprj_stb_i && !mprj_ack_o;
        cnt_enable_s = (state_r == ST_BUSY);
        timeout_evt_s = (state_r == ST_BUSY) && mprj_cyc_i && !ack_gated_s && cnt_expire_s;
    end

    wb_timeout_cnt #(
        .LIMIT (TIMEOUT_CYCLES)
    ) u_timeout_cnt (
        .clk    (core_clk),
        .rst    (core_rst),
        .clear  (accept_s),
        .enable (cnt_enable_s),
        .expire (cnt_expire_s)
    );

    // Transfer FSM with all bridge outputs registered.
    always_ff @(posedge core_clk) begin
        if (core_rst) begin
            state_r    <= ST_IDLE;
            wbs_cyc_o  <= 1'b0;
            wbs_stb_o  <= 1'b0;
            wbs_we_o   <= 1'b0;
            wbs_sel_o  <= 4'h0;
            wbs_adr_o  <= 32'h0000_0000;
            wbs_dat_o  <= 32'h0000_0000;
            mprj_ack_o <= 1'b0;
            mprj_dat_o <= 32'h0000_0000;
        end else begin
            case (state_r)
                ST_IDLE: begin
                    mprj_ack_o <= 1'b0;
                    if (accept_s) begin
                        wbs_we_o  <= mprj_we_i;
                        wbs_sel_o <= mprj_sel_i;
                        wbs_adr_o <= mprj_adr_i;
                        wbs_dat_o <= mprj_dat_i;
                        wbs_cyc_o <= 1'b1;
                        wbs_stb_o <= 1'b1;
                        state_r   <= ST_BUSY;
                    end else begin
                        state_r   <= ST_IDLE;
                    end
                end
                ST_BUSY: begin
                    if (!mprj_cyc_i) begin
                        wbs_cyc_o  <= 1'b0;
                        wbs_stb_o  <= 1'b0;
                        state_r    <= ST_IDLE;
                    end else if (ack_gated_s) begin
                        wbs_cyc_o  <= 1'b0;
                        wbs_stb_o  <= 1'b0;
                        mprj_dat_o <= dat_gated_s;
                        state_r    <= ST_RESP;
                    end else if (cnt_expire_s) begin
                        wbs_cyc_o  <= 1'b0;
                        wbs_stb_o  <= 1'b0;
                        mprj_dat_o <= TIMEOUT_DATA;
                        state_r    <= ST_RESP;
                    end else begin
                        state_r    <= ST_BUSY;
                    end
                end
                ST_RESP: begin
                    mprj_ack_o <= 1'b1;
                    state_r    <= ST_IDLE;
                end
                default: begin
                    wbs_cyc_o  <= 1'b0;
                    wbs_stb_o  <= 1'b0;
                    mprj_ack_o <= 1'b0;
                    state_r    <= ST_IDLE;
                end
            endcase
        end
    end

    // Sticky timeout status; a coincident new timeout beats to_clear.
    always_ff @(posedge core_clk) begin
        if (core_rst) begin
            to_flag <= 1'b0;
            to_addr <= 32'h0000_0000;
        end else if (timeout_evt_s && (!to_flag || to_clear)) begin
            to_flag <= 1'b1;
            to_addr <= wbs_adr_o;
        end else if (to_clear) begin
            to_flag <= 1'b0;
        end else begin
            to_flag <= to_flag;
        end
    end

endmodule

// File: tb/tb_mprj_wb_bridge.sv
// Directed bench for mprj_wb_bridge with TIMEOUT_CYCLES = 8.
module tb_mprj_wb_bridge;

    logic        core_clk = 1'b0;
    logic        core_rst;
    logic        mprj_cyc_i, mprj_stb_i, mprj_we_i;
    logic [3:0]  mprj_sel_i;
    logic [31:0] mprj_adr_i, mprj_dat_i;
    logic        mprj_ack_o;
    logic [31:0] mprj_dat_o;
    logic        wbs_cyc_o, wbs_stb_o, wbs_we_o;
    logic [3:0]  wbs_sel_o;
    logic [31:0] wbs_adr_o, wbs_dat_o;
    logic        wbs_ack_i;
    logic [31:0] wbs_dat_i;
    logic        mprj_wb_iena;
    logic        to_clear;
    logic        to_flag;
    logic [31:0] to_addr;

    int checks = 0;
    int errors = 0;

    mprj_wb_bridge #(
        .TIMEOUT_CYCLES (8),
        .TIMEOUT_DATA   (32'hFFFF_FFFF)
    ) dut (
        .core_clk     (core_clk),
        .core_rst     (core_rst),
        .mprj_cyc_i   (mprj_cyc_i),
        .mprj_stb_i   (mprj_stb_i),
        .mprj_we_i    (mprj_we_i),
        .mprj_sel_i   (mprj_sel_i),
        .mprj_adr_i   (mprj_adr_i),
        .mprj_dat_i   (mprj_dat_i),
        .mprj_ack_o   (mprj_ack_o),
        .mprj_dat_o   (mprj_dat_o),
        .wbs_cyc_o    (wbs_cyc_o),
        .wbs_stb_o    (wbs_stb_o),
        .wbs_we_o     (wbs_we_o),
        .wbs_sel_o    (wbs_sel_o),
        .wbs_adr_o    (wbs_adr_o),
        .wbs_dat_o    (wbs_dat_o),
        .wbs_ack_i    (wbs_ack_i),
        .wbs_dat_i    (wbs_dat_i),
        .mprj_wb_iena (mprj_wb_iena),
        .to_clear     (to_clear),
        .to_flag      (to_flag),
        .to_addr      (to_addr)
    );

    always #5 core_clk = ~core_clk;

    task automatic tick();
        @(posedge core_clk);
        #1;
    endtask

    // Present a request and step past the edge that accepts it.
    task automatic start_req(input logic we, input logic [3:0] sel,
                             input logic [31:0] adr, input logic [31:0] dat);
        mprj_cyc_i = 1'b1;
        mprj_stb_i = 1'b1;
        mprj_we_i  = we;
        mprj_sel_i = sel;
        mprj_adr_i = adr;
        mprj_dat_i = dat;
        tick();
    endtask

    task automatic wait_ack(output int n);
        n = 0;
        do begin
            tick();
            n++;
        end while (!mprj_ack_o && n < 40);
    endtask

    task automatic end_req();
        mprj_cyc_i = 1'b0;
        mprj_stb_i = 1'b0;
        wbs_ack_i  = 1'b0;
        wbs_dat_i  = 32'h0000_0000;
        tick();
    endtask

    task automatic test_reset();
        core_rst = 1'b1;
        mprj_cyc_i = 1'b0; mprj_stb_i = 1'b0; mprj_we_i = 1'b0;
        mprj_sel_i = 4'h0; mprj_adr_i = 32'h0; mprj_dat_i = 32'h0;
        wbs_ack_i = 1'b0; wbs_dat_i = 32'h0; mprj_wb_iena = 1'b1; to_clear = 1'b0;
        tick();
        tick();
        checks++;
        if ({wbs_cyc_o, wbs_stb_o, wbs_we_o, wbs_sel_o, wbs_adr_o, wbs_dat_o,
             mprj_ack_o, mprj_dat_o, to_flag, to_addr} !== 137'd0) begin
            errors++;
            $display("FAIL reset_state got adr=%h dat=%h mdat=%h cyc=%b ack=%b flag=%b want all 0",
                     wbs_adr_o, wbs_dat_o, mprj_dat_o, wbs_cyc_o, mprj_ack_o, to_flag);
        end
        core_rst = 1'b0;
        tick();
    endtask

    task automatic test_read();
        start_req(1'b0, 4'hF, 32'h3000_0000, 32'h0);
        checks++;
        if ({wbs_cyc_o, wbs_stb_o, wbs_we_o, wbs_adr_o} !== {1'b1, 1'b1, 1'b0, 32'h3000_0000}) begin
            errors++;
            $display("FAIL read_req got cyc=%b stb=%b we=%b adr=%h want 1 1 0 30000000",
                     wbs_cyc_o, wbs_stb_o, wbs_we_o, wbs_adr_o);
        end
        tick();
        tick();
        wbs_ack_i = 1'b1;
        wbs_dat_i = 32'hA5A5_1234;
        tick();
        checks++;
        if ({wbs_cyc_o, wbs_stb_o, mprj_ack_o} !== 3'b000) begin
            errors++;
            $display("FAIL read_strobe_drop got cyc=%b stb=%b ack=%b want 0 0 0",
                     wbs_cyc_o, wbs_stb_o, mprj_ack_o);
        end
        wbs_ack_i = 1'b0;
        wbs_dat_i = 32'h0;
        tick();
        checks++;
        if ({mprj_ack_o, mprj_dat_o} !== {1'b1, 32'hA5A5_1234}) begin
            errors++;
            $display("FAIL read_ack got ack=%b dat=%h want 1 a5a51234", mprj_ack_o, mprj_dat_o);
        end
        mprj_cyc_i = 1'b0;
        mprj_stb_i = 1'b0;
        tick();
        checks++;
        if ({mprj_ack_o, mprj_dat_o, to_flag} !== {1'b0, 32'hA5A5_1234, 1'b0}) begin
            errors++;
            $display("FAIL read_after got ack=%b dat=%h flag=%b want 0 a5a51234 0",
                     mprj_ack_o, mprj_dat_o, to_flag);
        end
    endtask

    task automatic test_write();
        int pulses = 0;
        logic [31:0] got = 32'h0;
        start_req(1'b1, 4'b0011, 32'h3000_0004, 32'h0000_BEEF);
        checks++;
        if ({wbs_we_o, wbs_sel_o, wbs_adr_o, wbs_dat_o} !==
            {1'b1, 4'b0011, 32'h3000_0004, 32'h0000_BEEF}) begin
            errors++;
            $display("FAIL write_req got we=%b sel=%b adr=%h dat=%h want 1 0011 30000004 0000beef",
                     wbs_we_o, wbs_sel_o, wbs_adr_o, wbs_dat_o);
        end
        wbs_ack_i = 1'b1;
        wbs_dat_i = 32'h5A5A_0F0F;
        for (int i = 0; i < 6; i++) begin
            tick();
            wbs_ack_i = 1'b0;
            if (mprj_ack_o) begin
                pulses++;
                got = mprj_dat_o;
                mprj_cyc_i = 1'b0;
                mprj_stb_i = 1'b0;
            end
        end
        checks++;
        if (pulses !== 1) begin
            errors++;
            $display("FAIL write_ack_pulses got %0d want 1", pulses);
        end
        checks++;
        if (got !== 32'h5A5A_0F0F) begin
            errors++;
            $display("FAIL write_return_data got %h want 5a5a0f0f", got);
        end
    endtask

    task automatic test_timeout();
        int n;
        start_req(1'b0, 4'hF, 32'h3000_0010, 32'h0);
        wait_ack(n);
        checks++;
        if (n !== 9) begin
            errors++;
            $display("FAIL timeout_latency got %0d want 9", n);
        end
        checks++;
        if ({mprj_dat_o, to_flag, to_addr, wbs_cyc_o} !== {32'hFFFF_FFFF, 1'b1, 32'h3000_0010, 1'b0}) begin
            errors++;
            $display("FAIL timeout_status got dat=%h flag=%b addr=%h cyc=%b want ffffffff 1 30000010 0",
                     mprj_dat_o, to_flag, to_addr, wbs_cyc_o);
        end
        end_req();
        start_req(1'b0, 4'hF, 32'h3000_0020, 32'h0);
        wait_ack(n);
        checks++;
        if ({n == 9, to_flag, to_addr} !== {1'b1, 1'b1, 32'h3000_0010}) begin
            errors++;
            $display("FAIL timeout_second got n=%0d flag=%b addr=%h want 9 1 30000010", n, to_flag, to_addr);
        end
        end_req();
    endtask

    task automatic test_clear_race();
        int n;
        start_req(1'b0, 4'hF, 32'h3000_0030, 32'h0);
        repeat (7) tick();
        to_clear = 1'b1;
        tick();
        to_clear = 1'b0;
        checks++;
        if ({to_flag, to_addr} !== {1'b1, 32'h3000_0030}) begin
            errors++;
            $display("FAIL clear_race got flag=%b addr=%h want 1 30000030", to_flag, to_addr);
        end
        wait_ack(n);
        checks++;
        if (n !== 1) begin
            errors++;
            $display("FAIL clear_race_ack got %0d want 1", n);
        end
        end_req();
    endtask

    task automatic test_iena();
        int n;
        to_clear = 1'b1;
        tick();
        to_clear = 1'b0;
        checks++;
        if (to_flag !== 1'b0) begin
            errors++;
            $display("FAIL clear_flag got %b want 0", to_flag);
        end
        mprj_wb_iena = 1'b0;
        start_req(1'b0, 4'hF, 32'h3000_0040, 32'h0);
        wbs_ack_i = 1'b1;
        wbs_dat_i = 32'h1234_5678;
        wait_ack(n);
        checks++;
        if ({n == 9, mprj_dat_o, to_flag, to_addr} !== {1'b1, 32'hFFFF_FFFF, 1'b1, 32'h3000_0040}) begin
            errors++;
            $display("FAIL iena_timeout got n=%0d dat=%h flag=%b addr=%h want 9 ffffffff 1 30000040",
                     n, mprj_dat_o, to_flag, to_addr);
        end
        end_req();
        mprj_wb_iena = 1'b1;
        to_clear = 1'b1;
        tick();
        to_clear = 1'b0;
        checks++;
        if (to_flag !== 1'b0) begin
            errors++;
            $display("FAIL iena_clear got %b want 0", to_flag);
        end
    endtask

    task automatic test_ack_at_expire();
        start_req(1'b0, 4'hF, 32'h3000_0050, 32'h0);
        repeat (7) tick();
        wbs_ack_i = 1'b1;
        wbs_dat_i = 32'hC0DE_0001;
        tick();
        wbs_ack_i = 1'b0;
        checks++;
        if (mprj_dat_o !== 32'hC0DE_0001) begin
            errors++;
            $display("FAIL ack_wins_data got %h want c0de0001", mprj_dat_o);
        end
        tick();
        checks++;
        if ({mprj_ack_o, to_flag} !== 2'b10) begin
            errors++;
            $display("FAIL ack_wins_status got ack=%b flag=%b want 1 0", mprj_ack_o, to_flag);
        end
        end_req();
    endtask

    task automatic test_abort();
        int acks = 0;
        start_req(1'b0, 4'hF, 32'h3000_0060, 32'h0);
        tick();
        tick();
        mprj_cyc_i = 1'b0;
        mprj_stb_i = 1'b0;
        tick();
        checks++;
        if ({wbs_cyc_o, wbs_stb_o} !== 2'b00) begin
            errors++;
            $display("FAIL abort_strobes got cyc=%b stb=%b want 0 0", wbs_cyc_o, wbs_stb_o);
        end
        repeat (12) begin
            tick();
            if (mprj_ack_o) acks++;
        end
        checks++;
        if ({acks == 0, to_flag} !== 2'b10) begin
            errors++;
            $display("FAIL abort_no_ack got acks=%0d flag=%b want 0 0", acks, to_flag);
        end
        start_req(1'b1, 4'hC, 32'h3000_0070, 32'h0000_1111);
        checks++;
        if ({wbs_cyc_o, wbs_adr_o} !== {1'b1, 32'h3000_0070}) begin
            errors++;
            $display("FAIL abort_then_idle got cyc=%b adr=%h want 1 30000070", wbs_cyc_o, wbs_adr_o);
        end
    endtask

    task automatic test_reset_mid();
        int n;
        core_rst = 1'b1;
        tick();
        checks++;
        if ({wbs_cyc_o, wbs_stb_o, wbs_we_o, wbs_sel_o, wbs_adr_o, wbs_dat_o,
             mprj_ack_o, mprj_dat_o, to_flag, to_addr} !== 137'd0) begin
            errors++;
            $display("FAIL reset_mid got adr=%h dat=%h mdat=%h cyc=%b addr=%h want all 0",
                     wbs_adr_o, wbs_dat_o, mprj_dat_o, wbs_cyc_o, to_addr);
        end
        mprj_cyc_i = 1'b0;
        mprj_stb_i = 1'b0;
        tick();
        core_rst = 1'b0;
        tick();
        start_req(1'b0, 4'hF, 32'h3000_0080, 32'h0);
        wbs_ack_i = 1'b1;
        wbs_dat_i = 32'h600D_F00D;
        wait_ack(n);
        checks++;
        if ({n == 2, mprj_dat_o, to_flag} !== {1'b1, 32'h600D_F00D, 1'b0}) begin
            errors++;
            $display("FAIL fresh_after_reset got n=%0d dat=%h flag=%b want 2 600df00d 0",
                     n, mprj_dat_o, to_flag);
        end
        end_req();
    endtask

    initial begin
        test_reset();
        test_read();
        test_write();
        test_timeout();
        test_clear_race();
        test_iena();
        test_ack_at_expire();
        test_abort();
        test_reset_mid();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog expired");
        $fatal(1);
    end

endmodule

// File: doc/mprj_wb_bridge.md
MPRJ_WB_BRIDGE -- requirements
Module: mprj_wb_bridge

Interface
REQ-001 Parameter TIMEOUT_CYCLES, default 255: cycles allowed for a user-project ack before forced termination (legal range 2..65535).
REQ-002 Parameter TIMEOUT_DATA, default 32'hFFFF_FFFF: read data returned on a timed-out transfer.
REQ-003 core_clk  in  1  sole clock; all logic is rising-edge.
REQ-004 core_rst  in  1  reset, synchronous and active-high.
REQ-005 mprj_cyc_i, mprj_stb_i, mprj_we_i  in  1 each  upstream wishbone request from the management core.
REQ-006 mprj_sel_i  in  4;  mprj_adr_i  in  32;  mprj_dat_i  in  32  upstream byte selects, address and write data.
REQ-007 mprj_ack_o  out  1;  mprj_dat_o  out  32  upstream acknowledge and read data.
REQ-008 wbs_cyc_o, wbs_stb_o, wbs_we_o  out  1 each;  wbs_sel_o  out  4;  wbs_adr_o, wbs_dat_o  out  32  registered request to the user project.
REQ-009 wbs_ack_i  in  1;  wbs_dat_i  in  32  user-project response.
REQ-010 mprj_wb_iena  in  1  when low, wbs_ack_i and wbs_dat_i are treated as 0.
REQ-011 to_clear  in  1  single-cycle pulse that clears the timeout status.
REQ-012 to_flag  out  1;  to_addr  out  32  sticky timeout indication and the address of the first timed-out transfer.

Function
REQ-013 The FSM has three states: IDLE, BUSY and RESP.
REQ-014 In IDLE, when mprj_cyc_i & mprj_stb_i, the bridge latches we/sel/adr/dat into the wbs_* registers, asserts wbs_cyc_o and wbs_stb_o on the next cycle, clears the counter, and enters BUSY.
REQ-015 In BUSY, the counter increments once per cycle.
REQ-016 In BUSY, a gated ack (wbs_ack_i & mprj_wb_iena) deasserts wbs_cyc_o/wbs_stb_o next cycle, captures wbs_dat_i into mprj_dat_o, and enters RESP.
REQ-017 In BUSY, when the counter reaches TIMEOUT_CYCLES-1 with no ack, the bridge drops the wbs strobes, loads TIMEOUT_DATA into mprj_dat_o, and enters RESP.
REQ-018 On a timeout with to_flag low, to_flag is set and the address is captured in to_addr; later timeouts leave to_addr unchanged until to_clear.
REQ-019 If ack and the final timeout cycle coincide, the ack wins: real data is returned and no timeout is recorded.
REQ-020 RESP asserts mprj_ack_o for exactly one cycle, then the FSM returns to IDLE.
REQ-021 Total latency: ack on wbs_ack_i at cycle N gives mprj_ack_o at cycle N+2; a new request is accepted no earlier than the cycle after mprj_ack_o.
REQ-022 If mprj_cyc_i drops while in BUSY, the bridge aborts: wbs strobes deassert next cycle, no mprj_ack_o is issued, the FSM returns to IDLE, and no timeout is recorded.
REQ-023 mprj_dat_o holds its last value outside RESP; writes return the captured wbs_dat_i unchanged.
REQ-024 If to_clear and a new timeout occur in the same cycle, the set wins: the flag stays 1 and to_addr is loaded.

Reset
REQ-025 On core_rst, the FSM goes to IDLE; all wbs_* outputs, mprj_ack_o, mprj_dat_o, to_flag, to_addr and the counter become 0.
REQ-026 Reset asserted mid-transfer takes effect at the next edge with no ack issued; the first request after reset release is treated as fresh.

Structure
REQ-027 The state encoding, default TIMEOUT_DATA and the counter width (clog2 of 65536) live in a shared package, mgmt_wb_pkg.
REQ-028 The timeout counter is one sub-module, wb_timeout_cnt, with clear/enable/expire ports; the FSM and registers stay in mprj_wb_bridge.

Verification
REQ-029 Read at 0x3000_0000, user acks after 3 cycles with 0xA5A5_1234 -> mprj_ack_o one cycle with 0xA5A5_1234, to_flag stays 0.
REQ-030 Write at 0x3000_0004 with sel 4'b0011 and data 0x0000_BEEF -> wbs_* carry identical values and mprj_ack_o is a single pulse.
REQ-031 TIMEOUT_CYCLES=8, no ack -> mprj_ack_o 9 cycles after acceptance with 0xFFFF_FFFF, to_flag=1, to_addr = request address; a second timeout at another address leaves to_addr unchanged.
REQ-032 mprj_wb_iena=0 while the user acks -> the transfer times out; to_clear pulse -> to_flag=0.
REQ-033 mprj_cyc_i dropped 2 cycles into BUSY -> no mprj_ack_o, wbs_cyc_o=0 next cycle, FSM back in IDLE; core_rst mid-BUSY -> all outputs 0 next edge.
